// File: rtl/jtkiwi_sub_bus.sv
// Sub CPU bus decoder: comm RAM port, ROM banking, IO selects,
// VBLANK interrupt and sub CPU reset sequencing.
module jtkiwi_sub_bus #(
    parameter int RST_HOLD = 16
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen6,
    input  logic        LVBL,
    input  logic        snd_rstn,
    output logic        cpu_rst,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        m1_n,
    input  logic        wr_n,
    output logic [7:0]  cpu_din,
    output logic        int_n,
    output logic        wait_n,
    output logic [12:0] shr_addr,
    output logic [7:0]  shr_din,
    output logic        shr_we,
    input  logic [7:0]  shr_dout,
    output logic [16:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [7:0]  rom_data,
    output logic        fm_cs,
    output logic        fm_a0,
    input  logic [7:0]  fm_dout,
    input  logic [7:0]  in0,
    input  logic [7:0]  in1
);

    localparam int CW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        RS_HOLD,
        RS_RELEASE,
        RS_RUN
    } rst_st_t;

    typedef enum logic [1:0] {
        WS_IDLE,
        WS_WR,
        WS_DONE
    } wr_st_t;

    rst_st_t       rst_st;
    wr_st_t        wr_st;
    logic [CW-1:0] rst_cnt;
    logic [2:0]    bank;
    logic [2:0]    win_bank;
    logic          ram_cs;
    logic          in0_cs;
    logic          in1_cs;
    logic          lvbl_l;

    logic rom_lo, rom_win, ram_rg, fm_rg;
    logic in0_rg, in1_rg, bank_rg;

    always_comb begin
        rom_lo  = !A[15];
        rom_win = A[15:14] == 2'b10;
        ram_rg  = A[15:13] == 3'b110;
        fm_rg   = A[15:1]  == 15'h7000;
        in0_rg  = A == 16'hE800;
        in1_rg  = A == 16'hE801;
        bank_rg = A == 16'hF000;
    end

    // 3-bit add so the window wraps: bank 6 -> 0, bank 7 -> 1
    assign win_bank = bank + 3'd2;
    assign wait_n   = !(rom_cs && !rom_ok);
    assign fm_a0    = A[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_st  <= RS_HOLD;
            rst_cnt <= '0;
            cpu_rst <= 1'b1;
        end else if (!snd_rstn) begin
            rst_st  <= RS_HOLD;
            rst_cnt <= '0;
            cpu_rst <= 1'b1;
        end else begin
            case (rst_st)
                RS_HOLD: begin
                    rst_st  <= RS_RELEASE;
                    rst_cnt <= '0;
                    cpu_rst <= 1'b1;
                end
                RS_RELEASE: begin
                    if (cen6) begin
                        if (rst_cnt == CW'(RST_HOLD - 1)) begin
                            rst_st  <= RS_RUN;
                            cpu_rst <= 1'b0;
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                end
                RS_RUN:  cpu_rst <= 1'b0;
                default: rst_st <= RS_HOLD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            ram_cs   <= 1'b0;
            fm_cs    <= 1'b0;
            in0_cs   <= 1'b0;
            in1_cs   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_cs <= !mreq_n && (rom_lo || rom_win);
            ram_cs <= !mreq_n && ram_rg;
            fm_cs  <= !mreq_n && fm_rg;
            in0_cs <= !mreq_n && in0_rg;
            in1_cs <= !mreq_n && in1_rg;
            if (!mreq_n && rom_lo)
                rom_addr <= {2'b00, A[14:0]};
            else if (!mreq_n && rom_win)
                rom_addr <= {win_bank, A[13:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_din <= 8'hFF;
        end else begin
            if (rom_cs) begin
                if (rom_ok) cpu_din <= rom_data;
            end else if (ram_cs) begin
                cpu_din <= shr_dout;
            end else if (fm_cs) begin
                cpu_din <= fm_dout;
            end else if (in0_cs) begin
                cpu_din <= in0;
            end else if (in1_cs) begin
                cpu_din <= in1;
            end else begin
                cpu_din <= 8'hFF;
            end
        end
    end

    // One strobe per Z80 write, however long wr_n stays low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st    <= WS_IDLE;
            shr_we   <= 1'b0;
            shr_addr <= '0;
            shr_din  <= '0;
            bank     <= '0;
        end else if (!snd_rstn) begin
            wr_st  <= WS_IDLE;
            shr_we <= 1'b0;
            bank   <= '0;
        end else begin
            if (!mreq_n && wr_n && ram_rg)
                shr_addr <= A[12:0];
            case (wr_st)
                WS_IDLE: begin
                    shr_we <= 1'b0;
                    if (!mreq_n && !wr_n) begin
                        wr_st <= WS_WR;
                        if (ram_rg) begin
                            shr_we   <= 1'b1;
                            shr_addr <= A[12:0];
                            shr_din  <= cpu_dout;
                        end
                        if (bank_rg) bank <= cpu_dout[2:0];
                    end
                end
                WS_WR: begin
                    shr_we <= 1'b0;
                    wr_st  <= WS_DONE;
                end
                WS_DONE: begin
                    shr_we <= 1'b0;
                    if (wr_n || mreq_n) wr_st <= WS_IDLE;
                end
                default: begin
                    shr_we <= 1'b0;
                    wr_st  <= WS_IDLE;
                end
            endcase
        end
    end

    // An acknowledge in the same clk as a new edge wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_n  <= 1'b1;
            lvbl_l <= 1'b1;
        end else begin
            lvbl_l <= LVBL;
            if (!snd_rstn)
                int_n <= 1'b1;
            else if (!iorq_n && !m1_n)
                int_n <= 1'b1;
            else if (lvbl_l && !LVBL)
                int_n <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtkiwi_sub_bus.sv
// Directed bench for jtkiwi_sub_bus: reset sequence, comm RAM
// writes, ROM banking, wait, IRQ and read mux.
module tb_jtkiwi_sub_bus;

    logic        rst, clk, cen6, LVBL, snd_rstn, cpu_rst;
    logic [15:0] A;
    logic [7:0]  cpu_dout, cpu_din, shr_din, shr_dout;
    logic        mreq_n, iorq_n, m1_n, wr_n, int_n, wait_n, shr_we;
    logic [12:0] shr_addr;
    logic [16:0] rom_addr;
    logic        rom_cs, rom_ok, fm_cs, fm_a0;
    logic [7:0]  rom_data, fm_dout, in0, in1;

    int total = 0;
    int bad   = 0;
    int n;
    logic [12:0] cap_addr;
    logic [7:0]  cap_din;

    jtkiwi_sub_bus #(.RST_HOLD(16)) dut (
        .rst(rst), .clk(clk), .cen6(cen6), .LVBL(LVBL),
        .snd_rstn(snd_rstn), .cpu_rst(cpu_rst), .A(A),
        .cpu_dout(cpu_dout), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .m1_n(m1_n), .wr_n(wr_n), .cpu_din(cpu_din),
        .int_n(int_n), .wait_n(wait_n), .shr_addr(shr_addr),
        .shr_din(shr_din), .shr_we(shr_we), .shr_dout(shr_dout),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_ok(rom_ok),
        .rom_data(rom_data), .fm_cs(fm_cs), .fm_a0(fm_a0),
        .fm_dout(fm_dout), .in0(in0), .in1(in1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic tick;
        cen6 = 1'b1;
        @(negedge clk);
        cen6 = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_bus;
        mreq_n = 1'b1;
        wr_n   = 1'b1;
        iorq_n = 1'b1;
        m1_n   = 1'b1;
    endtask

    task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
        A = a; cpu_dout = d; mreq_n = 1'b0; wr_n = 1'b0;
        clks(3);
        idle_bus();
        clks(2);
    endtask

    initial begin
        rst = 1'b1; cen6 = 1'b0; LVBL = 1'b1; snd_rstn = 1'b0;
        A = 16'h0; cpu_dout = 8'h0; idle_bus();
        shr_dout = 8'h11; rom_ok = 1'b1; rom_data = 8'h00;
        fm_dout = 8'hC7; in0 = 8'h5A; in1 = 8'hA5;
        clks(3);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_int_n", int_n, 1);
        chk("rst_shr_we", shr_we, 0);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_fm_cs", fm_cs, 0);
        chk("rst_cpu_din", cpu_din, 8'hFF);
        chk("rst_wait_n", wait_n, 1);
        rst = 1'b0;
        clks(2);
        chk("hold_no_snd", cpu_rst, 1);

        snd_rstn = 1'b1;
        clks(1);
        repeat (8) tick();
        snd_rstn = 1'b0;
        clks(1);
        chk("drop_at_8", cpu_rst, 1);
        snd_rstn = 1'b1;
        clks(1);
        repeat (15) tick();
        chk("restart_15", cpu_rst, 1);
        tick();
        chk("restart_16", cpu_rst, 0);

        A = 16'hC123; cpu_dout = 8'h5A; mreq_n = 1'b0; wr_n = 1'b0;
        n = 0; cap_addr = '0; cap_din = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (shr_we) begin
                n++;
                cap_addr = shr_addr;
                cap_din  = shr_din;
            end
        end
        idle_bus();
        clks(2);
        chk("we_once", n, 1);
        chk("we_addr", cap_addr, 13'h0123);
        chk("we_din", cap_din, 8'h5A);
        chk("addr_hold", shr_addr, 13'h0123);

        mem_wr(16'hF000, 8'h03);
        A = 16'h8004; mreq_n = 1'b0;
        clks(2);
        chk("bank3_cs", rom_cs, 1);
        chk("bank3_addr", rom_addr, 17'h14004);
        idle_bus();
        clks(1);
        mem_wr(16'hF000, 8'h07);
        A = 16'h8000; mreq_n = 1'b0;
        clks(2);
        chk("bank7_addr", rom_addr, 17'h04000);
        idle_bus();
        clks(2);
        chk("rom_cs_off", rom_cs, 0);

        A = 16'h0010; rom_ok = 1'b0; rom_data = 8'h00; mreq_n = 1'b0;
        clks(1);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (!wait_n) n++;
            @(negedge clk);
        end
        chk("wait_low_5", n, 5);
        chk("rom_addr_lo", rom_addr, 17'h00010);
        rom_ok = 1'b1; rom_data = 8'h3C;
        #1;
        chk("wait_release", wait_n, 1);
        clks(1);
        chk("rom_din", cpu_din, 8'h3C);
        idle_bus();
        clks(2);

        LVBL = 1'b0;
        clks(2);
        chk("irq_set", int_n, 0);
        iorq_n = 1'b0; m1_n = 1'b1;
        clks(2);
        chk("io_no_ack", int_n, 0);
        m1_n = 1'b0;
        clks(1);
        chk("irq_ack", int_n, 1);
        idle_bus(); LVBL = 1'b1;
        clks(2);
        LVBL = 1'b0; iorq_n = 1'b0; m1_n = 1'b0;
        clks(1);
        idle_bus();
        clks(2);
        chk("edge_ack_same", int_n, 1);

        A = 16'hE801; mreq_n = 1'b0;
        clks(3);
        chk("rd_in1", cpu_din, 8'hA5);
        A = 16'hE800;
        clks(3);
        chk("rd_in0", cpu_din, 8'h5A);
        A = 16'hF800;
        clks(3);
        chk("rd_unmapped", cpu_din, 8'hFF);
        A = 16'hE000;
        clks(3);
        chk("rd_fm", cpu_din, 8'hC7);
        chk("fm_cs", fm_cs, 1);
        chk("fm_a0", fm_a0, 0);
        idle_bus();
        clks(2);
        chk("fm_cs_off", fm_cs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
